// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - handshake and operand/result bundle for alu_pipe
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             InValid;
  logic             InReady;
  logic [3:0]       ALUOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Carry;

  modport master (
    output InValid, ALUOp, A, B, OutReady,
    input  InReady, OutValid, Result, Zero, Carry
  );

  modport slave (
    input  InValid, ALUOp, A, B, OutReady,
    output InReady, OutValid, Result, Zero, Carry
  );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshake and Carry/Zero flags
// Iterative shift-add multiply (op 1011) is built only when ALU_MUL_EN is defined.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic      CLK,
  input  logic      Reset,
  alu_pipe_if.slave bus
);
  localparam int               SHW    = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] W_LIM  = WIDTH'(WIDTH);
  localparam logic [3:0]       OP_MUL = 4'b1011;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;

  logic             w_out_free;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_single_load;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-2:0]   w_shamt;
  logic [WIDTH-1:0] w_res;
  logic             w_cy;

  assign w_out_free = !r_out_valid || bus.OutReady;
  assign w_sum      = {1'b0, bus.A} + {1'b0, bus.B};
  assign w_diff     = {1'b0, bus.A} - {1'b0, bus.B};
  assign w_shamt    = bus.A[SHW-2:0];

  always_comb begin
    w_res = '0;
    w_cy  = 1'b0;
    case (bus.ALUOp)
      4'b0000: begin w_res = w_sum[WIDTH-1:0]; w_cy = w_sum[WIDTH]; end
      4'b0001: w_res = bus.A | bus.B;
      4'b0010: w_res = bus.A & bus.B;
      4'b0011: w_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      4'b0100: w_res = {{(WIDTH-1){1'b0}}, (bus.A == bus.B)};
      4'b0101: w_res = {{(WIDTH-1){1'b0}}, (bus.A != bus.B)};
      4'b0110: w_res = (bus.A >= W_LIM) ? '0 : (bus.B >> w_shamt);
      4'b0111: w_res = (bus.A >= W_LIM) ? '0 : (bus.B << w_shamt);
      4'b1000: w_res = '0 - bus.B;
      4'b1001: begin w_res = w_diff[WIDTH-1:0]; w_cy = w_diff[WIDTH]; end
      4'b1010: w_res = bus.A ^ bus.B;
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t             r_state;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [SHW-1:0]     r_count;
  logic               w_mul_load;

  assign w_in_ready    = (r_state == S_IDLE) && w_out_free;
  assign w_accept      = bus.InValid && w_in_ready;
  assign w_single_load = w_accept && (bus.ALUOp != OP_MUL);
  assign w_mul_load    = (r_state == S_DONE) && w_out_free;

  // Partial product 0 is folded into the accept cycle so an unstalled
  // multiply reaches the output register WIDTH+1 cycles after accept.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && (bus.ALUOp == OP_MUL)) begin
            r_acc    <= bus.B[0] ? {{WIDTH{1'b0}}, bus.A} : '0;
            r_mcand  <= {{(WIDTH-1){1'b0}}, bus.A, 1'b0};
            r_mplier <= {1'b0, bus.B[WIDTH-1:1]};
            r_count  <= SHW'(1);
            r_state  <= S_MUL;
          end
        end
        S_MUL: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
          if (r_count == CNT_LAST) r_state <= S_DONE;
        end
        S_DONE: begin
          if (w_out_free) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign w_in_ready    = w_out_free;
  assign w_accept      = bus.InValid && w_in_ready;
  assign w_single_load = w_accept;
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
    end else begin
`ifdef ALU_MUL_EN
      if (w_mul_load) begin
        r_result    <= r_acc[WIDTH-1:0];
        r_zero      <= (r_acc[WIDTH-1:0] == '0);
        r_carry     <= |r_acc[2*WIDTH-1:WIDTH];
        r_out_valid <= 1'b1;
      end else
`endif
      if (w_single_load) begin
        r_result    <= w_res;
        r_zero      <= (w_res == '0);
        r_carry     <= w_cy;
        r_out_valid <= 1'b1;
      end else if (bus.OutReady) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.InReady  = w_in_ready;
  assign bus.OutValid = r_out_valid;
  assign bus.Result   = r_result;
  assign bus.Zero     = r_zero;
  assign bus.Carry    = r_carry;
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe (WIDTH=8), either ALU_MUL_EN setting
module tb_alu_pipe;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(8)) bus ();
  alu_pipe #(.WIDTH(8)) dut (.CLK(clk), .Reset(rst), .bus(bus));

  typedef struct {
    int op; int a; int b;
    int res; int z; int c; int lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model(input int op, input int a, input int b,
                                output int r, output int c, output int lat);
    int p;
    r = 0; c = 0; lat = 1;
    case (op)
      0:  begin p = a + b; r = p % 256; c = (p >= 256); end
      1:  r = a | b;
      2:  r = a & b;
      3:  r = (a < b) ? 1 : 0;
      4:  r = (a == b) ? 1 : 0;
      5:  r = (a != b) ? 1 : 0;
      6:  r = (a >= 8) ? 0 : (b >> a);
      7:  r = (a >= 8) ? 0 : ((b << a) % 256);
      8:  r = (256 - b) % 256;
      9:  begin r = (a - b + 256) % 256; c = (a < b); end
      10: r = a ^ b;
`ifdef ALU_MUL_EN
      11: begin p = a * b; r = p % 256; c = (p >= 256); lat = 9; end
`endif
      default: r = 0;
    endcase
  endfunction

  // Entered just after a rising edge; leaves just after the edge that pops the result.
  task automatic run_op(input int op, input int a, input int b,
                        output int res, output int z, output int c,
                        output int lat, output int ready_low);
    bit got;
    bus.InValid = 1'b1;
    bus.ALUOp   = op[3:0];
    bus.A       = a[7:0];
    bus.B       = b[7:0];
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.InReady) begin got = 1'b1; break; end
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    lat = -1; ready_low = 1; res = -1; z = -1; c = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.OutValid) begin
        lat = k; res = bus.Result; z = bus.Zero; c = bus.Carry;
        break;
      end
      if (bus.InReady) ready_low = 0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, z, c, lat, rl, er, ec, el, a, b, op, saw;

    vecs[0]  = '{0, 1, 4, 5, 0, 0, 1};
    vecs[1]  = '{1, 8'hAA, 8'h55, 8'hFF, 0, 0, 1};
    vecs[2]  = '{2, 8'h0F, 8'h00, 0, 1, 0, 1};
    vecs[3]  = '{0, 8'hFF, 8'h01, 0, 1, 1, 1};
    vecs[4]  = '{9, 3, 5, 8'hFE, 0, 1, 1};
    vecs[5]  = '{3, 14, 15, 1, 0, 0, 1};
    vecs[6]  = '{6, 6, 8'hC0, 8'h03, 0, 0, 1};
    vecs[7]  = '{7, 8, 8'hAA, 0, 1, 0, 1};
    vecs[8]  = '{8, 0, 8'h0F, 8'hF1, 0, 0, 1};
    vecs[9]  = '{4, 5, 5, 1, 0, 0, 1};
    vecs[10] = '{5, 5, 5, 0, 1, 0, 1};
    vecs[11] = '{10, 8'hF0, 8'h3C, 8'hCC, 0, 0, 1};
    vecs[12] = '{12, 8'h12, 8'h34, 0, 1, 0, 1};
`ifdef ALU_MUL_EN
    vecs[13] = '{11, 8'h10, 8'h11, 8'h10, 0, 1, 9};
`else
    vecs[13] = '{11, 8'h10, 8'h11, 0, 1, 0, 1};
`endif

    rst = 1'b1;
    bus.InValid = 1'b0; bus.ALUOp = 4'd0; bus.A = 8'd0; bus.B = 8'd0; bus.OutReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outvalid", bus.OutValid, 0);
    check("rst_result", bus.Result, 0);
    check("rst_zero", bus.Zero, 0);
    check("rst_carry", bus.Carry, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_inready", bus.InReady, 1);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, c, lat, rl);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_zero", i), z, vecs[i].z);
      check($sformatf("vec%0d_carry", i), c, vecs[i].c);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_inready_low", i), rl, 1);
    end

    // back-to-back single-cycle ops, one result per cycle
    bus.InValid = 1'b1; bus.ALUOp = 4'd0; bus.A = 8'd1; bus.B = 8'd4;
    @(negedge clk); check("b2b_ready0", bus.InReady, 1);
    @(posedge clk); #1 bus.ALUOp = 4'd1; bus.A = 8'hAA; bus.B = 8'h55;
    @(negedge clk);
    check("b2b_valid0", bus.OutValid, 1); check("b2b_res0", bus.Result, 5);
    check("b2b_ready1", bus.InReady, 1);
    @(posedge clk); #1 bus.ALUOp = 4'd2; bus.A = 8'h0F; bus.B = 8'h00;
    @(negedge clk);
    check("b2b_valid1", bus.OutValid, 1); check("b2b_res1", bus.Result, 8'hFF);
    @(posedge clk); #1 bus.InValid = 1'b0;
    @(negedge clk);
    check("b2b_valid2", bus.OutValid, 1); check("b2b_res2", bus.Result, 0);
    check("b2b_zero2", bus.Zero, 1);
    @(posedge clk); #1;
    @(negedge clk); check("b2b_drained", bus.OutValid, 0);
    @(posedge clk); #1;

    // backpressure, then simultaneous pop and load
    bus.OutReady = 1'b0;
    bus.InValid = 1'b1; bus.ALUOp = 4'd0; bus.A = 8'd2; bus.B = 8'd3;
    @(posedge clk); #1 bus.ALUOp = 4'd10; bus.A = 8'h11; bus.B = 8'h22;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", bus.OutValid, 1);
      check("bp_inready", bus.InReady, 0);
      check("bp_result", bus.Result, 5);
      @(posedge clk); #1;
    end
    bus.OutReady = 1'b1; bus.ALUOp = 4'd1; bus.A = 8'h30; bus.B = 8'h03;
    @(negedge clk); check("bp_release_ready", bus.InReady, 1);
    @(posedge clk); #1 bus.InValid = 1'b0;
    @(negedge clk);
    check("bp_swap_valid", bus.OutValid, 1); check("bp_swap_result", bus.Result, 8'h33);
    @(posedge clk); #1;
    @(negedge clk); check("bp_swap_drained", bus.OutValid, 0);
    @(posedge clk); #1;

    // asynchronous reset with a held result
    bus.OutReady = 1'b0;
    bus.InValid = 1'b1; bus.ALUOp = 4'd0; bus.A = 8'hFF; bus.B = 8'h02;
    @(posedge clk); #1 bus.InValid = 1'b0;
    @(negedge clk); check("rst2_pre_result", bus.Result, 1);
    #2 rst = 1'b1;
    #1;
    check("rst2_outvalid", bus.OutValid, 0);
    check("rst2_result", bus.Result, 0);
    check("rst2_zero", bus.Zero, 0);
    check("rst2_carry", bus.Carry, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0; bus.OutReady = 1'b1;
    @(negedge clk); check("rst2_inready", bus.InReady, 1);
    @(posedge clk); #1;

    // reset three cycles into a multiply aborts it
    bus.InValid = 1'b1; bus.ALUOp = 4'd11; bus.A = 8'd3; bus.B = 8'd5;
    @(posedge clk); #1 bus.InValid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    saw = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.OutValid) saw = 1;
    end
    check("mul_abort_no_valid", saw, 0);
    @(posedge clk); #1;
    run_op(0, 7, 8, r, z, c, lat, rl);
    check("post_abort_result", r, 15);
    check("post_abort_latency", lat, 1);

    // randomized ops against the arithmetic model
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 15);
      a  = (op == 6 || op == 7) ? $urandom_range(0, 12) : $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      if (n % 10 == 0) b = a;
      model(op, a, b, er, ec, el);
      run_op(op, a, b, r, z, c, lat, rl);
      check($sformatf("rnd%0d_op%0d_result", n, op), r, er);
      check($sformatf("rnd%0d_op%0d_zero", n, op), z, (er == 0) ? 1 : 0);
      check($sformatf("rnd%0d_op%0d_carry", n, op), c, ec);
      check($sformatf("rnd%0d_op%0d_latency", n, op), lat, el);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU; sits between register-file read and writeback in the Divvy datapath.
- Adds a valid/ready handshake on input and output, an output register with backpressure, and Carry/Zero flags.
- Adds a multi-cycle iterative multiply op driven by a small FSM.
- Keeps the existing ALUOp encoding 0000-1000 unchanged, so the current decoder drives it directly.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- SHW, $clog2(WIDTH)+1, width of the shift-amount field taken from A (derived; do not override).

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- InValid  input  1  ALUOp/A/B are valid this cycle.
- InReady  output  1  block accepts input this cycle.
- ALUOp  input  4  operation select.
- A  input  WIDTH  operand A (shift amount for shifts).
- B  input  WIDTH  operand B.
- OutValid  output  1  Result/Zero/Carry are valid.
- OutReady  input  1  consumer takes the result this cycle.
- Result  output  WIDTH  registered result.
- Zero  output  1  registered, Result == 0.
- Carry  output  1  registered carry/borrow/overflow flag (see below).

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; OutValid=0; Result=0; Zero=0; Carry=0. Reset mid-multiply aborts the op; no result is produced.
- InReady = (state==IDLE) && (!OutValid || OutReady). This is combinational from state and the output register only; it never depends on InValid.
- Accept = InValid && InReady. ALUOp/A/B are captured only on accept.
- Output register is held stable while OutValid && !OutReady.
- OutValid clears on OutReady unless a new result loads in the same cycle. A simultaneous pop and load keeps OutValid=1 with the new data.
- Single-cycle ops have latency 1: accept in cycle N gives OutValid=1 in N+1. Full throughput is one op per cycle with OutReady held high.
- Op codes, all unsigned, WIDTH bits:
  - 0000 add A+B; Carry = carry-out.
  - 0001 or.
  - 0010 and.
  - 0011 less-than: Result = (A<B) ? 1 : 0.
  - 0100 equal: Result 1 if A==B.
  - 0101 not-equal: Result 1 if A!=B.
  - 0110 shift right: B >> A.
  - 0111 shift left: B << A.
  - 1000 negate: two's complement of B.
  - 1001 sub A-B; Carry = borrow (A<B).
  - 1010 xor.
  - 1011 multiply A*B; Result = low WIDTH bits; Carry = OR of the high WIDTH bits.
  - 1100-1111: Result=0.
- Shift rule: if A >= WIDTH (any bit of A at or above SHW-1 set beyond WIDTH-1), Result=0.
- Carry=0 for every op except add, sub and multiply. Zero is always (Result==0), computed from the value being loaded.
- FSM states:
  - IDLE: on accept of 1011, load multiplicand=A, multiplier=B, acc=0, count=0, and go to MUL. Other ops load the output register directly and stay in IDLE.
  - MUL: one shift-add step per cycle (add multiplicand<<count into the 2*WIDTH accumulator if multiplier bit[count] is set). After WIDTH steps go to DONE.
  - DONE: load the output register when it is empty or being popped (!OutValid || OutReady), then go to IDLE. Otherwise wait in DONE.
- Multiply latency is WIDTH+1 cycles from accept to OutValid when unstalled. InReady=0 throughout MUL and DONE.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: multiply datapath and the MUL/DONE states are built exactly as above.
- Undefined: no multiplier and no MUL/DONE states. Op 1011 is treated like 1100-1111: single-cycle, Result=0, Zero=1, Carry=0.

Test Plan:
- Reset asserted mid-stream, then released -> OutValid=0, Result=0, Zero=0, Carry=0, InReady=1 after release. Assert Reset 3 cycles into a multiply -> no OutValid afterwards; next op is accepted normally.
- WIDTH=8, OutReady=1, back-to-back accepts: add 1+4, or 8'hAA|8'h55, and 8'h0F&8'h00 -> Results 5, 8'hFF, 0 (Zero=1) on consecutive cycles, one per cycle.
- Add 8'hFF+8'h01 -> Result 0, Zero=1, Carry=1. Sub 3-5 -> Result 8'hFE, Carry=1. Less-than 14<15 -> 1.
- Shifts: A=6, B=8'hC0, op 0110 -> 8'h03. A=8, B=8'hAA, op 0111 -> 0. Negate B=8'h0F -> 8'hF1.
- Backpressure: hold OutReady=0 with OutValid=1 -> InReady=0 and Result stable for 5 cycles. Raise OutReady and present a new op in the same cycle -> OutValid stays 1 and the new result appears the next cycle.
- ALU_MUL_EN defined: 8'h10*8'h11 -> Result 8'h10, Carry=1, OutValid exactly 9 cycles after accept, InReady=0 meanwhile. Not defined: same op -> Result 0, Zero=1 after 1 cycle.
